posit_add_result_buffer: RTL and testbench
==========================================

POSIT_ADD_RESULT_BUFFER -- requirements
Module: posit_add_result_buffer

Interface
REQ-001 Parameter N, default 8: posit width, matching the 8-bit adder datapath.
REQ-002 Parameter DEPTH, default 16: FIFO entries; power of two, at least 2.
REQ-003 Parameter LAT, default 7: adder start-to-done latency in aclk cycles.
REQ-004 aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 aresetn  in  1  reset, synchronous, active-low.
REQ-006 issue  in  1  pulse when the upstream stage drives start to the adder.
REQ-007 issue_ok  out  1  high when one more adder operation may start without risk of result loss.
REQ-008 add_done  in  1  adder done strobe.
REQ-009 add_result  in  N  adder result.
REQ-010 add_inf, add_zero  in  1 each  adder flags.
REQ-011 m_valid  out  1; m_ready  in  1: downstream valid/ready handshake.
REQ-012 m_data  out  N+2  {inf, zero, result}.
REQ-013 ovf_err  out  1  sticky flag: a result was dropped.
REQ-014 level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Write on each aclk edge with add_done=1 and FIFO not full; write data {add_inf, add_zero, add_result}.
REQ-016 Read on each edge with m_valid=1 and m_ready=1; pop the head entry.
REQ-017 m_valid and m_data are registered; a word written into an empty FIFO appears on m_valid exactly 1 cycle after the write edge, i.e. no fall-through.
REQ-018 m_data holds stable while m_valid=1 and m_ready=0.
REQ-019 Simultaneous read and write: allowed when full and when empty (the empty case follows REQ-017 timing); level is unchanged when both occur.
REQ-020 Read and write pointers wrap modulo DEPTH; full = level==DEPTH; empty = level==0.
REQ-021 inflight counter, width $clog2(DEPTH)+1:
- +1 on issue;
- -1 on add_done;
- unchanged when both occur on the same edge;
- saturates at 0 and never underflows.
REQ-022 issue_ok = (level + inflight) < DEPTH; purely combinational from registered state.
REQ-023 An issue made while issue_ok=0 is still counted; the resulting overflow is handled by REQ-024.
REQ-024 add_done while full and no simultaneous read: the result is dropped and ovf_err is set to 1 until reset.
REQ-025 m_data content while m_valid=0 is don't-care; the bench shall not check it.

Reset
REQ-026 When aresetn=0 at an edge, the following reset to 0: m_valid, level, inflight, pointers, ovf_err, and the counters of REQ-029.
REQ-027 Reset mid-operation discards all stored and in-flight bookkeeping.
REQ-028 After reset, add_done pulses from operations issued before reset are accepted if space exists; inflight stays saturated at 0.

Configuration
REQ-029 Macro POSIT_BUF_STATS_EN:
- Defined: adds output ports inf_cnt and zero_cnt, 16 bits each, incrementing on each written entry with the respective flag set and wrapping at 2^16.
- Undefined: these ports and counters are absent and all other behaviour is identical.

Structure
REQ-030 Shared package posit_pkg holds:
- constants POSIT_N=8, POSIT_ADD_LAT=7;
- packed struct posit_res_t {inf, zero, result[N-1:0]}.
REQ-031 Storage is one sub-module, posit_buf_ram: simple dual-port, registered read, DEPTH x (N+2), no reset on the array.

Verification
REQ-032 Reset, then a single issue; 7 cycles later add_done with result=8'h40, inf=0, zero=0 -> m_valid rises one cycle later with m_data=10'h040; level=1; inflight=0.
REQ-033 DEPTH=16, m_ready=0, 16 back-to-back issues -> issue_ok falls after the 16th issue; after 16 done pulses level=16 and ovf_err=0.
REQ-034 Full FIFO, m_ready=0, a 17th add_done with result=8'h7F -> ovf_err=1, level stays 16, and the dropped word never appears on m_data.
REQ-035 Full FIFO, m_ready=1 and add_done on the same edge -> level stays 16, the head pops and the new word is written at the tail; order is preserved (FIFO, 20-word sequence check).
REQ-036 Result 8'h80 with inf=1, then 8'h00 with zero=1 -> m_data=10'h280 then 10'h100; with POSIT_BUF_STATS_EN, inf_cnt=1 and zero_cnt=1.
REQ-037 aresetn=0 for one cycle with level=5 and inflight=3 -> m_valid=0, level=0, ovf_err=0; 3 late add_done pulses are then stored and inflight stays 0.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit adder constants and the buffered result word layout.
package posit_pkg;

    localparam int POSIT_N       = 8;
    localparam int POSIT_ADD_LAT = 7;

    typedef struct packed {
        logic               inf;
        logic               zero;
        logic [POSIT_N-1:0] result;
    } posit_res_t;

    function automatic posit_res_t mk_res(
        input logic               inf,
        input logic               zero,
        input logic [POSIT_N-1:0] result
    );
        posit_res_t r;
        r.inf    = inf;
        r.zero   = zero;
        r.result = result;
        return r;
    endfunction

endpackage

// File: rtl/posit_buf_ram.sv
// Simple dual-port result storage, one write port and one registered read port.
module posit_buf_ram #(
    parameter int W     = 10,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/posit_add_result_buffer.sv
// Result FIFO behind the posit adder with issue credit tracking.
// Optional flag counters are enabled with POSIT_BUF_STATS_EN.
module posit_add_result_buffer
    import posit_pkg::*;
#(
    parameter int N     = POSIT_N,
    parameter int DEPTH = 16,
    parameter int LAT   = POSIT_ADD_LAT
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       issue,
    output logic                       issue_ok,
    input  logic                       add_done,
    input  logic [N-1:0]               add_result,
    input  logic                       add_inf,
    input  logic                       add_zero,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [N+1:0]               m_data,
    output logic                       ovf_err,
`ifdef POSIT_BUF_STATS_EN
    output logic [15:0]                inf_cnt,
    output logic [15:0]                zero_cnt,
`endif
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LAT < 1) begin : g_bad_cfg
        $error("posit_add_result_buffer: DEPTH must be a power of two >= 2, LAT >= 1");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] inflight;
    logic [LW-1:0] pending;
    logic [LW:0]   committed;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          load;

    assign full      = (level == LW'(DEPTH));
    assign pop       = m_valid & m_ready;
    assign wr_en     = add_done & (~full | pop);
    // words stored in the RAM that are not yet in the output register
    assign pending   = level - LW'(m_valid);
    assign load      = (pending != '0) & (~m_valid | pop);
    assign committed = {1'b0, level} + {1'b0, inflight};
    assign issue_ok  = (committed < (LW + 1)'(DEPTH));

    posit_buf_ram #(
        .W     (N + 2),
        .DEPTH (DEPTH)
    ) u_ram (
        .aclk  (aclk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({add_inf, add_zero, add_result}),
        .re    (load),
        .raddr (rd_ptr),
        .rdata (m_data)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            m_valid  <= 1'b0;
            ovf_err  <= 1'b0;
            inflight <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(wr_en) - LW'(pop);
            if (load) begin
                m_valid <= 1'b1;
            end else if (pop) begin
                m_valid <= 1'b0;
            end
            if (add_done && full && !pop) begin
                ovf_err <= 1'b1;
            end
            unique case (1'b1)
                issue && !add_done: begin
                    if (inflight != '1) begin
                        inflight <= inflight + LW'(1);
                    end
                end
                add_done && !issue: begin
                    if (inflight != '0) begin
                        inflight <= inflight - LW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef POSIT_BUF_STATS_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            inf_cnt  <= '0;
            zero_cnt <= '0;
        end else if (wr_en) begin
            inf_cnt  <= inf_cnt + 16'(add_inf);
            zero_cnt <= zero_cnt + 16'(add_zero);
        end
    end
`endif

endmodule

// File: tb/tb_posit_add_result_buffer.sv
// Scoreboard bench for posit_add_result_buffer: directed scenarios plus random traffic.
module tb_posit_add_result_buffer;
    import posit_pkg::*;

    localparam int N     = POSIT_N;
    localparam int DEPTH = 16;
    localparam int LAT   = POSIT_ADD_LAT;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          aclk       = 1'b0;
    logic          aresetn    = 1'b0;
    logic          issue      = 1'b0;
    logic          issue_ok;
    logic          add_done   = 1'b0;
    logic [N-1:0]  add_result = '0;
    logic          add_inf    = 1'b0;
    logic          add_zero   = 1'b0;
    logic          m_valid;
    logic          m_ready    = 1'b0;
    logic [N+1:0]  m_data;
    logic          ovf_err;
    logic [LW-1:0] level;
`ifdef POSIT_BUF_STATS_EN
    logic [15:0]   inf_cnt;
    logic [15:0]   zero_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 aclk = ~aclk;

    posit_add_result_buffer #(
        .N     (N),
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .issue      (issue),
        .issue_ok   (issue_ok),
        .add_done   (add_done),
        .add_result (add_result),
        .add_inf    (add_inf),
        .add_zero   (add_zero),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .ovf_err    (ovf_err),
`ifdef POSIT_BUF_STATS_EN
        .inf_cnt    (inf_cnt),
        .zero_cnt   (zero_cnt),
`endif
        .level      (level)
    );

    // behavioural adder: fixed-latency pipe of results
    posit_res_t pipe_d [LAT];
    bit         pipe_v [LAT];

    task automatic cycle(input bit iss, input bit rdy, input bit rst,
                         input posit_res_t r);
        aresetn  = !rst;
        issue    = iss;
        m_ready  = rdy;
        add_done = pipe_v[LAT-1];
        {add_inf, add_zero, add_result} = pipe_d[LAT-1];
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[0] = iss;
        pipe_d[0] = r;
        @(posedge aclk);
        #1;
    endtask

    function automatic posit_res_t rnd_res();
        return mk_res(($urandom % 8) == 0, ($urandom % 8) == 0,
                      N'($urandom));
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: queue of stored words tagged with their write edge
    typedef struct {
        posit_res_t d;
        int         w;
    } ent_t;

    ent_t        q[$];
    int          infl    = 0;
    bit          ovf     = 1'b0;
    int          edge_no = 0;
    logic [15:0] ic      = '0;
    logic [15:0] zc      = '0;

    always @(negedge aclk) begin
        bit exp_valid;
        bit pop;
        bit full;
        edge_no++;
        // a word becomes visible one edge after the edge that wrote it
        exp_valid = (q.size() > 0) && (q[0].w < edge_no);
        check("m_valid", 32'(m_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("m_data", 32'(m_data), 32'(q[0].d));
        end
        check("level", 32'(level), 32'(q.size()));
        check("issue_ok", 32'(issue_ok), 32'((q.size() + infl) < DEPTH));
        check("ovf_err", 32'(ovf_err), 32'(ovf));
`ifdef POSIT_BUF_STATS_EN
        check("inf_cnt", 32'(inf_cnt), 32'(ic));
        check("zero_cnt", 32'(zero_cnt), 32'(zc));
`endif
        if (!aresetn) begin
            q.delete();
            infl = 0;
            ovf  = 1'b0;
            ic   = '0;
            zc   = '0;
        end else begin
            pop  = exp_valid && m_ready;
            full = (q.size() == DEPTH);
            if (pop) begin
                void'(q.pop_front());
            end
            if (add_done) begin
                if (!full || pop) begin
                    q.push_back('{d: mk_res(add_inf, add_zero, add_result),
                                  w: edge_no + 1});
                    ic = ic + 16'(add_inf);
                    zc = zc + 16'(add_zero);
                end else begin
                    ovf = 1'b1;
                end
            end
            if (issue && !add_done) begin
                infl++;
            end else if (!issue && add_done && infl > 0) begin
                infl--;
            end
        end
    end

    initial begin
        posit_res_t z;
        z = '0;
        for (int i = 0; i < LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        repeat (2) cycle(0, 0, 1, z);

        // single operation, then pop it
        cycle(1, 0, 0, mk_res(1'b0, 1'b0, 8'h40));
        repeat (LAT + 2) cycle(0, 0, 0, z);
        cycle(0, 1, 0, z);
        repeat (2) cycle(0, 0, 0, z);

        // fill to DEPTH, then one extra result that must be dropped
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, rnd_res());
        cycle(1, 0, 0, mk_res(1'b0, 1'b0, 8'h7F));
        repeat (LAT + 3) cycle(0, 0, 0, z);

        // full FIFO with simultaneous pop and push for 20 words
        for (int i = 0; i < 20 + LAT; i++) begin
            cycle(i < 20, i >= LAT, 0, rnd_res());
        end
        repeat (DEPTH + 4) cycle(0, 1, 0, z);

        // flag-carrying results
        cycle(1, 0, 0, mk_res(1'b1, 1'b0, 8'h80));
        cycle(1, 0, 0, mk_res(1'b0, 1'b1, 8'h00));
        repeat (LAT + 3) cycle(0, 0, 0, z);
        repeat (4) cycle(0, 1, 0, z);

        // reset with level 5 and 3 in flight; late results still land
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, rnd_res());
        repeat (3) cycle(0, 0, 0, z);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, rnd_res());
        cycle(0, 0, 0, z);
        cycle(0, 0, 1, z);
        repeat (LAT + 3) cycle(0, 0, 0, z);
        repeat (6) cycle(0, 1, 0, z);

        // random traffic with stall windows that provoke overflow
        for (int i = 0; i < 800; i++) begin
            bit rdy;
            rdy = ((i / 60) % 3 == 1) ? 1'b0 : (($urandom % 4) != 0);
            cycle(($urandom % 2) == 1, rdy, 0, rnd_res());
        end
        repeat (LAT + DEPTH + 6) cycle(0, 1, 0, z);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
